// File: rtl/fetch_controller.sv
// Instruction fetch: owns the PC, drives the sync ROM, presents instructions to decode via valid/ready.
// Latency 2 cycles issue->if_valid; decode stalls land in a 1-entry skid and issue throttles at occupancy 2.
module fetch_controller #(
    parameter int width_B          = 32,
    parameter int Addr_B           = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [Addr_B-1:0]  redirect_addr,
    output logic               rom_en,
    output logic [Addr_B-1:0]  rom_addr,
    input  logic [width_B-1:0] rom_dout,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [width_B-1:0] if_instr,
    output logic [Addr_B-1:0]  if_pc,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state;
    logic [Addr_B-1:0]   pc;
    logic                inflight;
    logic [Addr_B-1:0]   inflight_pc;
    logic                skid_valid;
    logic [width_B-1:0]  skid_instr;
    logic [Addr_B-1:0]   skid_pc;

    logic                consume;
    logic                issue;
    logic [1:0]          occ;

    assign consume = if_valid && if_ready;
    assign occ     = {1'b0, if_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    // A slot freed by this cycle's consume may be refilled by this cycle's issue.
    assign issue   = (state == S_RUN) && !redirect_valid
                     && ((occ - {1'b0, consume}) < 2'd2);

    assign rom_en   = issue;
    assign rom_addr = pc;
    assign busy     = (state == S_RUN) || inflight || if_valid || skid_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= Addr_B'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
        end else if (redirect_valid) begin
            // Flush everything, including a return landing this cycle.
            pc         <= redirect_addr;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            if_valid   <= 1'b0;
            if (halt_req && state == S_RUN)
                state <= S_HALT;
        end else begin
            case (state)
                S_IDLE:  if (start && !halt_req) state <= S_RUN;
                S_RUN:   if (halt_req) state <= S_HALT;
                S_HALT:  if (start && !halt_req) state <= S_RUN;
                default: state <= S_IDLE;
            endcase

            if (issue)
                pc <= pc + Addr_B'(1);
            inflight    <= issue;
            inflight_pc <= pc;

            if (!if_valid || if_ready) begin
                if (skid_valid) begin
                    if_valid   <= 1'b1;
                    if_instr   <= skid_instr;
                    if_pc      <= skid_pc;
                    skid_valid <= inflight;
                    if (inflight) begin
                        skid_instr <= rom_dout;
                        skid_pc    <= inflight_pc;
                    end
                end else if (inflight) begin
                    if_valid <= 1'b1;
                    if_instr <= rom_dout;
                    if_pc    <= inflight_pc;
                end else begin
                    if_valid <= 1'b0;
                end
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_instr <= rom_dout;
                skid_pc    <= inflight_pc;
            end
        end
    end

endmodule
